tour_cmd_sequencer: RTL and testbench

- Host-side command player that sits directly upstream of RemoteComm.
- Holds a programmed list of 16-bit Knight commands, e.g. the gyro calibrate command, then 16'h4BF4.
- Issues the commands one at a time through RemoteComm's snd_cmd/cmd_snt handshake.
- Waits for each 8-bit response, checks it against the positive acknowledge, then advances.
- Replaces hand-sequenced SendCmd/ChkPosAck calls for multi-move tours and is usable as a synthesizable remote.

---
 rtl/tour_cmd_sequencer.sv | 161 ++++++++++++++++
 tb/tb_tour_cmd_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tour_cmd_sequencer.sv
// Host-side command player for RemoteComm: plays a loaded list of 16-bit Knight
// commands one at a time and checks each response byte against the positive ack.
module tour_cmd_sequencer #(
   parameter int          DEPTH      = 32,
   parameter logic [7:0]  ACK_VAL    = 8'hA5,
   parameter logic [23:0] TMO_CYCLES = 24'd10_000_000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [15:0]              wr_data,
   input  logic                     clr_list,
   input  logic                     start,
   input  logic                     abort,
   output logic [15:0]              cmd,
   output logic                     snd_cmd,
   input  logic                     cmd_snt,
   input  logic                     resp_rdy,
   input  logic [7:0]               resp,
   output logic                     busy,
   output logic                     done,
   output logic                     err,
   output logic [1:0]               err_code,
   output logic [$clog2(DEPTH)-1:0] err_idx,
   output logic [7:0]               bad_resp,
   output logic [$clog2(DEPTH):0]   list_len
);
   localparam int          IW   = $clog2(DEPTH);
   localparam logic [IW:0] FULL = (IW+1)'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_SEND, S_WAIT_SNT, S_WAIT_RESP, S_DONE, S_ERR
   } state_t;

   state_t        state, state_n;
   logic [15:0]   mem [DEPTH];
   logic [IW-1:0] idx;
   logic [23:0]   cnt;

   logic          mem_we, len_clr, play, nxt, ld_cmd, cnt_clr, fail;
   logic [1:0]    fail_code;
   logic          last_slot;

   assign last_slot = ({1'b0, idx} == (list_len - 1'b1));

   always_comb begin
      state_n   = state;
      mem_we    = 1'b0;
      len_clr   = 1'b0;
      play      = 1'b0;
      nxt       = 1'b0;
      ld_cmd    = 1'b0;
      cnt_clr   = 1'b0;
      fail      = 1'b0;
      fail_code = 2'd0;
      case (state)
         S_IDLE, S_DONE, S_ERR: begin
            // start beats clr_list beats wr_en; loading only while IDLE
            if (start) begin
               play    = 1'b1;
               state_n = (list_len == '0) ? S_DONE : S_LOAD;
            end else if (clr_list) begin
               len_clr = 1'b1;
               state_n = S_IDLE;
            end else if (wr_en && state == S_IDLE && list_len != FULL) begin
               mem_we = 1'b1;
            end
         end
         S_LOAD: begin
            ld_cmd  = 1'b1;
            state_n = S_SEND;
         end
         S_SEND: begin
            if (abort) begin
               fail      = 1'b1;
               fail_code = 2'd3;
            end else begin
               state_n = S_WAIT_SNT;
            end
         end
         S_WAIT_SNT: begin
            if (abort) begin
               fail      = 1'b1;
               fail_code = 2'd3;
            end else if (cmd_snt) begin
               cnt_clr = 1'b1;
               state_n = S_WAIT_RESP;
            end
         end
         S_WAIT_RESP: begin
            // a response on the limit cycle still counts as a response
            if (abort) begin
               fail      = 1'b1;
               fail_code = 2'd3;
            end else if (resp_rdy) begin
               if (resp == ACK_VAL) begin
                  if (last_slot) begin
                     state_n = S_DONE;
                  end else begin
                     nxt     = 1'b1;
                     state_n = S_LOAD;
                  end
               end else begin
                  fail      = 1'b1;
                  fail_code = 2'd1;
               end
            end else if (cnt == TMO_CYCLES - 24'd1) begin
               fail      = 1'b1;
               fail_code = 2'd2;
            end
         end
         default: state_n = S_IDLE;
      endcase
      if (fail) state_n = S_ERR;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         cmd      <= '0;
         idx      <= '0;
         cnt      <= '0;
         err_code <= '0;
         err_idx  <= '0;
         bad_resp <= '0;
         list_len <= '0;
      end else begin
         state <= state_n;
         if (mem_we)  list_len <= list_len + 1'b1;
         if (len_clr) begin
            list_len <= '0;
            err_code <= '0;
         end
         if (play) begin
            idx      <= '0;
            err_code <= '0;
         end
         if (nxt)    idx <= idx + 1'b1;
         if (ld_cmd) cmd <= mem[idx];
         if (cnt_clr)                    cnt <= '0;
         else if (state == S_WAIT_RESP)  cnt <= cnt + 24'd1;
         if (fail) begin
            err_code <= fail_code;
            err_idx  <= idx;
            if (fail_code == 2'd1) bad_resp <= resp;
         end
      end
   end

   // storage is deliberately left out of reset so it can map onto RAM
   always_ff @(posedge clk) begin
      if (mem_we && !rst) mem[list_len[IW-1:0]] <= wr_data;
   end

   assign snd_cmd = (state == S_SEND);
   assign busy    = (state == S_LOAD) || (state == S_SEND) ||
                    (state == S_WAIT_SNT) || (state == S_WAIT_RESP);
   assign done    = (state == S_DONE);
   assign err     = (state == S_ERR);

endmodule

// File: tb/tb_tour_cmd_sequencer.sv
// Bench for tour_cmd_sequencer: the bench plays RemoteComm, keeps a list-player
// model, and compares every output every cycle, plus directed literal checks.
module tb_tour_cmd_sequencer;
   localparam int DEPTH = 32;
   localparam int IW    = 5;
   localparam int TMO   = 100;

   logic        clk = 1'b0;
   logic        rst, wr_en, clr_list, start, abort, cmd_snt, resp_rdy;
   logic [15:0] wr_data;
   logic [7:0]  resp;
   logic [15:0] cmd;
   logic        snd_cmd, busy, done, err;
   logic [1:0]  err_code;
   logic [IW-1:0] err_idx;
   logic [7:0]  bad_resp;
   logic [IW:0] list_len;

   always #5 clk = ~clk;

   tour_cmd_sequencer #(.DEPTH(DEPTH), .ACK_VAL(8'hA5), .TMO_CYCLES(24'd100)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .clr_list(clr_list),
      .start(start), .abort(abort), .cmd(cmd), .snd_cmd(snd_cmd), .cmd_snt(cmd_snt),
      .resp_rdy(resp_rdy), .resp(resp), .busy(busy), .done(done), .err(err),
      .err_code(err_code), .err_idx(err_idx), .bad_resp(bad_resp), .list_len(list_len)
   );

   int total = 0, bad = 0, cyc = 0, last_snt = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         if (bad < 40) $display("FAIL %s got=%0h want=%0h cycle=%0d", name, act, exp, cyc);
      end
   endtask

   // ---------------- model: list player described by its rules ----------------
   int          m_len, m_idx, m_pre, m_wait, m_code, m_eidx, m_bad;
   logic [15:0] m_mem [DEPTH];
   logic [15:0] m_cmd;
   bit          m_play, m_tx, m_rx, m_done, m_err;

   task automatic m_fail(input int c);
      m_play = 0; m_pre = -1; m_tx = 0; m_rx = 0;
      m_err = 1; m_code = c; m_eidx = m_idx;
   endtask

   // m_pre: 1 = fetching the slot, 0 = request cycle, -1 = not in lead-in
   task automatic model_step();
      if (rst) begin
         m_len = 0; m_play = 0; m_pre = -1; m_tx = 0; m_rx = 0; m_idx = 0; m_wait = 0;
         m_done = 0; m_err = 0; m_code = 0; m_eidx = 0; m_bad = 0; m_cmd = '0;
      end else if (!m_play) begin
         if (start) begin
            m_done = 0; m_err = 0; m_code = 0;
            if (m_len == 0) m_done = 1;
            else begin m_play = 1; m_idx = 0; m_pre = 1; end
         end else if (clr_list) begin
            m_len = 0; m_done = 0; m_err = 0; m_code = 0;
         end else if (wr_en && !m_done && !m_err && m_len < DEPTH) begin
            m_mem[m_len] = wr_data; m_len++;
         end
      end else if (m_pre == 1) begin
         m_cmd = m_mem[m_idx]; m_pre = 0;
      end else if (abort) m_fail(3);
      else if (m_pre == 0) begin m_pre = -1; m_tx = 1; end
      else if (m_tx) begin
         if (cmd_snt) begin m_tx = 0; m_rx = 1; m_wait = 0; end
      end else if (m_rx) begin
         if (resp_rdy) begin
            if (resp == 8'hA5) begin
               m_rx = 0;
               if (m_idx == m_len - 1) begin m_play = 0; m_done = 1; end
               else begin m_idx++; m_pre = 1; end
            end else begin
               m_bad = resp; m_fail(1);
            end
         end else if (m_wait == TMO - 1) m_fail(2);
         else m_wait++;
      end
   endtask

   task automatic compare();
      chk("busy", busy, m_play);
      chk("snd_cmd", snd_cmd, (m_play && m_pre == 0) ? 1 : 0);
      chk("done", done, m_done);
      chk("err", err, m_err);
      chk("err_code", err_code, m_code);
      chk("err_idx", err_idx, m_eidx);
      chk("bad_resp", bad_resp, m_bad);
      chk("list_len", list_len, m_len);
      chk("cmd", cmd, m_cmd);
   endtask

   // ---------------- RemoteComm stand-in ----------------
   int          r_st, r_cnt, r_val;
   int          plan[$];
   logic [15:0] sent_q[$];
   bit          stray_en, ack_only, abort_on_resp;

   task automatic resp_observe();
      if (snd_cmd) begin
         sent_q.push_back(cmd);
         r_st  = 1;
         r_cnt = $urandom_range(1, 4);
         if (plan.size() > 0) r_val = plan.pop_front();
         else if (ack_only) r_val = 8'hA5;
         else begin
            int p, b;
            p = $urandom_range(0, 99);
            b = $urandom_range(0, 254);
            if (b >= 8'hA5) b++;
            r_val = (p < 85) ? 8'hA5 : (p < 93) ? b : -1;
         end
      end
   endtask

   task automatic resp_drive();
      cmd_snt = 1'b0; resp_rdy = 1'b0;
      if (r_st == 1) begin
         if (r_cnt == 0) begin cmd_snt = 1'b1; r_st = 2; r_cnt = $urandom_range(0, 5); end
         else r_cnt--;
      end else if (r_st == 2) begin
         if (r_val >= 0) begin
            if (r_cnt == 0) begin
               resp_rdy = 1'b1; resp = r_val[7:0]; r_st = 0;
               if (abort_on_resp) abort = 1'b1;
            end else r_cnt--;
         end
      end else if (stray_en && $urandom_range(0, 15) == 0) begin
         if ($urandom_range(0, 1) == 1) cmd_snt = 1'b1;
         else begin resp_rdy = 1'b1; resp = 8'($urandom); end
      end
   endtask

   task automatic tick();
      resp_drive();
      @(posedge clk);
      cyc++;
      if (cmd_snt) last_snt = cyc;
      model_step();
      if (rst) r_st = 0;
      @(negedge clk);
      compare();
      resp_observe();
      wr_en = 0; start = 0; clr_list = 0; abort = 0; rst = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1; plan.delete(); sent_q.delete(); r_st = 0;
      tick();
   endtask

   task automatic load(input logic [15:0] v);
      wr_en = 1'b1; wr_data = v; tick();
   endtask

   task automatic run_to_end(input int budget, input string name);
      int n = 0;
      while (!(done || err) && n < budget) begin tick(); n++; end
      chk(name, (done || err) ? 1 : 0, 1);
   endtask

   logic [15:0] w [33];

   initial begin
      rst = 1; wr_en = 0; wr_data = '0; clr_list = 0; start = 0; abort = 0;
      cmd_snt = 0; resp_rdy = 0; resp = '0;
      r_st = 0; r_cnt = 0; r_val = 0; stray_en = 0; ack_only = 0; abort_on_resp = 0;
      do_reset(); do_reset();
      chk("rst_len", list_len, 0);
      chk("rst_snd", snd_cmd, 0);
      chk("rst_code", err_code, 0);
      chk("rst_cmd", cmd, 0);

      // two-command tour, both acked
      load(16'h2000); load(16'h4BF4);
      plan = '{8'hA5, 8'hA5}; sent_q.delete();
      start = 1; tick();
      run_to_end(200, "t1_end");
      chk("t1_nsent", sent_q.size(), 2);
      chk("t1_c0", sent_q[0], 16'h2000);
      chk("t1_c1", sent_q[1], 16'h4BF4);
      chk("t1_done", done, 1);
      chk("t1_err", err, 0);
      chk("t1_busy", busy, 0);

      // bad second response
      clr_list = 1; tick();
      load(16'h1111); load(16'h2222); load(16'h3333);
      plan = '{8'hA5, 8'h5A}; sent_q.delete();
      start = 1; tick();
      run_to_end(200, "t2_end");
      repeat (10) tick();
      chk("t2_err", err, 1);
      chk("t2_code", err_code, 1);
      chk("t2_idx", err_idx, 1);
      chk("t2_bad", bad_resp, 8'h5A);
      chk("t2_nsent", sent_q.size(), 2);

      // silent responder -> timeout exactly TMO clocks after cmd_snt
      clr_list = 1; tick();
      load(16'h0C0D);
      plan = '{-1}; sent_q.delete();
      start = 1; tick();
      run_to_end(400, "t3_end");
      chk("t3_code", err_code, 2);
      chk("t3_idx", err_idx, 0);
      chk("t3_latency", cyc - last_snt, 100);

      // overfill, then play full list while poking wr_en
      clr_list = 1; tick();
      for (int i = 0; i < 33; i++) begin
         w[i] = 16'h8000 + 16'(i * 7);
         load(w[i]);
      end
      chk("t4_len", list_len, 32);
      ack_only = 1; sent_q.delete();
      start = 1; tick();
      for (int n = 0; n < 2000 && !(done || err); n++) begin
         if (n % 3 == 0) begin wr_en = 1; wr_data = 16'hFFFF; end
         tick();
      end
      chk("t4_end", done, 1);
      chk("t4_nsent", sent_q.size(), 32);
      chk("t4_len2", list_len, 32);
      for (int i = 0; i < 32; i++) chk("t4_cmd", sent_q[i], w[i]);
      ack_only = 0;

      // abort colliding with an ack, then replay
      clr_list = 1; tick();
      load(16'hAAAA); load(16'hBBBB);
      plan = '{8'hA5}; abort_on_resp = 1; sent_q.delete();
      start = 1; tick();
      run_to_end(200, "t5_end");
      abort_on_resp = 0;
      repeat (20) tick();
      chk("t5_code", err_code, 3);
      chk("t5_idx", err_idx, 0);
      chk("t5_nsent", sent_q.size(), 1);
      plan = '{8'hA5, 8'hA5};
      start = 1; tick();
      run_to_end(200, "t5b_end");
      chk("t5_done", done, 1);
      chk("t5_replay0", sent_q[1], 16'hAAAA);
      chk("t5_replay1", sent_q[2], 16'hBBBB);

      // reset while waiting for a response
      clr_list = 1; tick();
      load(16'h1234); load(16'h5678);
      plan = '{-1};
      start = 1; tick();
      repeat (15) tick();
      chk("t6_busy_pre", busy, 1);
      do_reset();
      chk("t6_len", list_len, 0);
      chk("t6_busy", busy, 0);
      chk("t6_err", err, 0);
      chk("t6_cmd", cmd, 0);
      start = 1; tick();
      chk("t6_done", done, 1);
      chk("t6_busy2", busy, 0);

      // random traffic including stray handshakes, aborts and resets
      stray_en = 1;
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 2) == 0) begin wr_en = 1; wr_data = 16'($urandom); end
         if ($urandom_range(0, 11) == 0) start = 1;
         if ($urandom_range(0, 49) == 0) clr_list = 1;
         if ($urandom_range(0, 59) == 0) abort = 1;
         if ($urandom_range(0, 699) == 0) rst = 1;
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog cycle=%0d", cyc);
      $fatal(1);
   end
endmodule
